// File: rtl/itcm_ifu_icb_slv_pkg.sv
// ----------------------------------------------------------------------------
// itcm_ifu_icb_slv_pkg
// Shared widths and helpers for the ITCM fetch-port ICB responder.
// The widths follow the standard 16-bit address / 64-bit line ITCM
// configuration.
// ----------------------------------------------------------------------------
package itcm_ifu_icb_slv_pkg;

  localparam int ITCM_ADDR_WIDTH = 16;
  localparam int ITCM_DATA_WIDTH = 64;

  // Byte offset bits inside one 64-bit SRAM line.
  localparam int ITCM_WORD_LSB = 3;

  // Instruction fetches must be at least halfword aligned. Only bit 0 of
  // the byte address decides whether the fetch is illegal.
  function automatic logic fetch_misaligned(input logic addr_bit0);
    logic bad_s;
    bad_s = (addr_bit0 == 1'b1);
    return bad_s;
  endfunction

endpackage

// File: rtl/itcm_rsp_hold.sv
// ----------------------------------------------------------------------------
// itcm_rsp_hold
// Read-data path of the ITCM fetch responder. In the cycle right after an
// SRAM access ("fresh"), the SRAM output is passed straight through. If the
// response stalls in that cycle, the line is copied into data_r, so that a
// later access by another SRAM agent cannot disturb the pending response.
// Error responses always return zero data.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   ram_cs      - this block's SRAM access in the current cycle
//   rsp_err     - registered error of the pending response
//   rsp_ready   - response accepted by the fetch unit
//   ram_dout    - SRAM read data (valid the cycle after ram_cs)
//   rsp_rdata   - response read data
// ----------------------------------------------------------------------------
module itcm_rsp_hold #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_cs,
  input  logic          rsp_err,
  input  logic          rsp_ready,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] rsp_rdata
);

  logic          fresh_r;
  logic          data_lden_s;
  logic [DW-1:0] data_r;

  sirv_gnrl_dffr #(.DW(1)) u_fresh_dff (
    .dnxt  (ram_cs),
    .qout  (fresh_r),
    .clk   (clk),
    .rst_n (rst_n)
  );

  // Capture only when the fresh line is about to be lost by a stall.
  assign data_lden_s = fresh_r & ~rsp_ready;

  sirv_gnrl_dfflr #(.DW(DW)) u_data_dff (
    .lden  (data_lden_s),
    .dnxt  (ram_dout),
    .qout  (data_r),
    .clk   (clk),
    .rst_n (rst_n)
  );

  // Response data select: zero on error, live SRAM when fresh, else held copy
  always_comb begin
    rsp_rdata = '0;
    if (rsp_err) begin
      rsp_rdata = '0;
    end else if (fresh_r) begin
      rsp_rdata = ram_dout;
    end else begin
      rsp_rdata = data_r;
    end
  end

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// ----------------------------------------------------------------------------
// sirv_gnrl_dfflr
// General-purpose flop with a load enable and an async active-low reset
// to zero.
// Ports: lden (load enable), dnxt (next value), qout (registered value),
//        clk, rst_n.
// ----------------------------------------------------------------------------
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  logic [DW-1:0] qout_r;

  // Load-enabled state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_r <= '0;
    end else if (lden) begin
      qout_r <= dnxt;
    end else begin
      qout_r <= qout_r;
    end
  end

  assign qout = qout_r;

endmodule

// File: rtl/sirv_gnrl_dffr.sv
// ----------------------------------------------------------------------------
// sirv_gnrl_dffr
// General-purpose flop that loads every cycle and has an async active-low
// reset to zero.
// Ports: dnxt (next value), qout (registered value), clk, rst_n.
// ----------------------------------------------------------------------------
module sirv_gnrl_dffr #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  logic [DW-1:0] qout_r;

  // Free-running state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_r <= '0;
    end else begin
      qout_r <= dnxt;
    end
  end

  assign qout = qout_r;

endmodule

// File: rtl/itcm_ifu_icb_slv.sv
// ----------------------------------------------------------------------------
// itcm_ifu_icb_slv
// ITCM-side ICB responder for the instruction-fetch port. It accepts one
// read command at a time, drives the 64-bit ITCM SRAM and returns the
// line (or an error for a byte-misaligned fetch) one cycle later. The
// ifu2itcm_holdup flag tells the fetch unit that the SRAM output still
// holds the line of its last successful read.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   ifu2itcm_icb_cmd_valid/ready/addr - fetch command channel
//   ifu2itcm_icb_rsp_valid/ready/err/rdata - fetch response channel
//   ifu2itcm_holdup             - SRAM output equals last IFU read
//   ext_sram_busy               - another agent owns the SRAM this cycle
//   itcm_ram_cs/addr            - SRAM chip select and word address
//   itcm_ram_dout               - SRAM read data
// ----------------------------------------------------------------------------
module itcm_ifu_icb_slv
  import itcm_ifu_icb_slv_pkg::*;
#(
  parameter int AW  = ITCM_ADDR_WIDTH,
  parameter int DW  = ITCM_DATA_WIDTH,
  parameter int RAW = AW - 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ifu2itcm_icb_cmd_valid,
  output logic           ifu2itcm_icb_cmd_ready,
  input  logic [AW-1:0]  ifu2itcm_icb_cmd_addr,
  output logic           ifu2itcm_icb_rsp_valid,
  input  logic           ifu2itcm_icb_rsp_ready,
  output logic           ifu2itcm_icb_rsp_err,
  output logic [DW-1:0]  ifu2itcm_icb_rsp_rdata,
  output logic           ifu2itcm_holdup,
  input  logic           ext_sram_busy,
  output logic           itcm_ram_cs,
  output logic [RAW-1:0] itcm_ram_addr,
  input  logic [DW-1:0]  itcm_ram_dout
);

  logic       cmd_hs_s;
  logic       rsp_hs_s;
  logic       err_c_s;
  logic       rsp_valid_r;
  logic       rsp_valid_lden_s;
  logic       rsp_valid_nxt_s;
  logic       err_r;
  logic       holdup_r;
  logic       holdup_lden_s;
  logic       holdup_nxt_s;
  logic [1:0] unused_addr_bits_s;

  // Halfword offset inside a line does not matter: the whole line is read.
  assign unused_addr_bits_s = ifu2itcm_icb_cmd_addr[2:1];

  // Command acceptance, error check and SRAM request
  always_comb begin
    ifu2itcm_icb_cmd_ready = 1'b0;
    cmd_hs_s               = 1'b0;
    rsp_hs_s               = 1'b0;
    err_c_s                = 1'b0;
    itcm_ram_cs            = 1'b0;
    // A new command may enter in the cycle the pending response leaves.
    if (ext_sram_busy) begin
      ifu2itcm_icb_cmd_ready = 1'b0;
    end else begin
      ifu2itcm_icb_cmd_ready = ~rsp_valid_r | ifu2itcm_icb_rsp_ready;
    end
    cmd_hs_s    = ifu2itcm_icb_cmd_valid & ifu2itcm_icb_cmd_ready;
    rsp_hs_s    = rsp_valid_r & ifu2itcm_icb_rsp_ready;
    err_c_s     = fetch_misaligned(ifu2itcm_icb_cmd_addr[0]);
    itcm_ram_cs = cmd_hs_s & ~err_c_s;
  end

  assign itcm_ram_addr = RAW'(ifu2itcm_icb_cmd_addr[AW-1:ITCM_WORD_LSB]);

  // Response-valid and holdup next-state terms
  always_comb begin
    rsp_valid_lden_s = 1'b0;
    rsp_valid_nxt_s  = 1'b0;
    holdup_lden_s    = 1'b0;
    holdup_nxt_s     = 1'b0;
    // A handshake without a replacing command empties the response slot.
    rsp_valid_lden_s = cmd_hs_s | rsp_hs_s;
    rsp_valid_nxt_s  = cmd_hs_s;
    // Any other-agent access invalidates the SRAM output for the IFU.
    if (ext_sram_busy) begin
      holdup_lden_s = 1'b1;
      holdup_nxt_s  = 1'b0;
    end else if (cmd_hs_s) begin
      holdup_lden_s = 1'b1;
      holdup_nxt_s  = ~err_c_s;
    end else begin
      holdup_lden_s = 1'b0;
      holdup_nxt_s  = holdup_r;
    end
  end

  sirv_gnrl_dfflr #(.DW(1)) u_rsp_valid_dff (
    .lden  (rsp_valid_lden_s),
    .dnxt  (rsp_valid_nxt_s),
    .qout  (rsp_valid_r),
    .clk   (clk),
    .rst_n (rst_n)
  );

  sirv_gnrl_dfflr #(.DW(1)) u_rsp_err_dff (
    .lden  (cmd_hs_s),
    .dnxt  (err_c_s),
    .qout  (err_r),
    .clk   (clk),
    .rst_n (rst_n)
  );

  sirv_gnrl_dfflr #(.DW(1)) u_holdup_dff (
    .lden  (holdup_lden_s),
    .dnxt  (holdup_nxt_s),
    .qout  (holdup_r),
    .clk   (clk),
    .rst_n (rst_n)
  );

  itcm_rsp_hold #(.DW(DW)) u_rsp_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .ram_cs    (itcm_ram_cs),
    .rsp_err   (err_r),
    .rsp_ready (ifu2itcm_icb_rsp_ready),
    .ram_dout  (itcm_ram_dout),
    .rsp_rdata (ifu2itcm_icb_rsp_rdata)
  );

  assign ifu2itcm_icb_rsp_valid = rsp_valid_r;
  assign ifu2itcm_icb_rsp_err   = err_r;
  assign ifu2itcm_holdup        = holdup_r;

endmodule

// File: tb/tb_itcm_ifu_icb_slv.sv
// ----------------------------------------------------------------------------
// tb_itcm_ifu_icb_slv
// Self-checking bench for the ITCM fetch-port responder. A behavioural
// SRAM (with a second agent that reads random lines while busy) surrounds
// the DUT. A reference model tracks the one-deep response slot, the
// expected line and the holdup flag.
// ----------------------------------------------------------------------------
module tb_itcm_ifu_icb_slv;

  localparam int AW    = 16;
  localparam int DW    = 64;
  localparam int RAW   = 13;
  localparam int WORDS = 8192;

  logic           clk;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_addr;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_err;
  logic [DW-1:0]  rsp_rdata;
  logic           holdup;
  logic           sram_busy;
  logic           ram_cs;
  logic [RAW-1:0] ram_addr;
  logic [DW-1:0]  ram_dout;

  logic [DW-1:0]  mem [0:WORDS-1];

  int n_vec;
  int n_err;

  // Reference model state
  bit             m_pend;
  bit             m_err;
  logic [DW-1:0]  m_data;
  bit             m_hold;

  itcm_ifu_icb_slv dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ifu2itcm_icb_cmd_valid (cmd_valid),
    .ifu2itcm_icb_cmd_ready (cmd_ready),
    .ifu2itcm_icb_cmd_addr  (cmd_addr),
    .ifu2itcm_icb_rsp_valid (rsp_valid),
    .ifu2itcm_icb_rsp_ready (rsp_ready),
    .ifu2itcm_icb_rsp_err   (rsp_err),
    .ifu2itcm_icb_rsp_rdata (rsp_rdata),
    .ifu2itcm_holdup        (holdup),
    .ext_sram_busy          (sram_busy),
    .itcm_ram_cs            (ram_cs),
    .itcm_ram_addr          (ram_addr),
    .itcm_ram_dout          (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: the IFU read has priority; otherwise the other agent reads a random line
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_dout <= mem[ram_addr];
    end else if (sram_busy) begin
      ram_dout <= mem[13'($urandom_range(0, WORDS - 1))];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check against the model, advance the model
  task automatic step(input bit v, input logic [AW-1:0] a, input bit rr, input bit busy);
    bit exp_ready;
    bit hs;
    bit mis;
    @(negedge clk);
    cmd_valid = v;
    cmd_addr  = a;
    rsp_ready = rr;
    sram_busy = busy;
    #1;
    exp_ready = !busy && (!m_pend || rr);
    hs        = v && exp_ready;
    mis       = a[0];
    chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
    chk("ram_cs", 64'(ram_cs), 64'(hs && !mis));
    if (hs && !mis) chk("ram_addr", 64'(ram_addr), 64'(a >> 3));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_pend));
    if (m_pend) begin
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      chk("rsp_rdata", rsp_rdata, m_data);
    end
    chk("holdup", 64'(holdup), 64'(m_hold));
    // model update for the coming edge
    if (hs) begin
      m_pend = 1'b1;
      m_err  = mis;
      m_data = mis ? 64'd0 : mem[a >> 3];
    end else if (m_pend && rr) begin
      m_pend = 1'b0;
    end
    if (busy) m_hold = 1'b0;
    else if (hs) m_hold = !mis;
  endtask

  initial begin
    logic [AW-1:0] ra;
    n_vec = 0;
    n_err = 0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_data = '0;
    m_hold = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[i] = {$urandom, $urandom};
    ram_dout  = '0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    rsp_ready = 1'b0;
    sram_busy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_holdup", 64'(holdup), 64'd0);
    chk("rst_ram_cs", 64'(ram_cs), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch
    step(1'b1, 16'h0010, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    // Back-to-back fetch
    step(1'b1, 16'h0008, 1'b1, 1'b0);
    step(1'b1, 16'h0010, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    // Stall while the other agent uses the SRAM
    step(1'b1, 16'h0008, 1'b0, 1'b0);
    step(1'b1, 16'h0020, 1'b0, 1'b0);
    step(1'b1, 16'h0020, 1'b0, 1'b1);
    step(1'b1, 16'h0020, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    // Misaligned fetch
    step(1'b1, 16'h0011, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    // Busy blocking, then acceptance as busy drops
    step(1'b1, 16'h0028, 1'b1, 1'b1);
    step(1'b1, 16'h0028, 1'b1, 1'b1);
    step(1'b1, 16'h0028, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ra = {13'($urandom_range(0, WORDS - 1)), 2'($urandom_range(0, 3)), 1'b0};
      if ($urandom_range(0, 7) == 0) ra[0] = 1'b1;
      step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0);
    end

    // Async reset with a pending, stalled response
    step(1'b1, 16'h0040, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    sram_busy = 1'b0;
    #2;
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_holdup", 64'(holdup), 64'd0);
    chk("arst_ram_cs", 64'(ram_cs), 64'd0);
    chk("arst_rsp_rdata", rsp_rdata, 64'd0);
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0018, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
